// File: rtl/inst_mem_resp.sv
// Instruction memory with a byte-serial program loader (LOAD) and a
// single-cycle-latency fetch port (RUN). Misaligned or out-of-range fetches return a NOP.
module inst_mem_resp #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall_req,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_done,
  output logic        fetch_err,
  output logic        load_ovf
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {LOAD, RUN} state_t;

  state_t            state, state_next;
  logic [1:0]        cnt, cnt_next;
  logic [31:0]       asm_q, asm_next;
  logic [ADDR_W:0]   wp;
  logic              word_full, word_part, word_wr, wr_en;
  logic [ADDR_W-1:0] ridx;
  logic              aligned, in_range;
  logic              rd_ok_q, hit_q;
  logic [31:0]       rd_q;
  logic [31:0]       mem [0:DEPTH-1];

  assign ridx     = addr[ADDR_W+1:2];
  assign aligned  = (addr[1:0] == 2'b00);
  assign in_range = (addr[31:ADDR_W+2] == '0);

  always_comb begin
    state_next = state;
    stall_req  = (state == LOAD);
    asm_next   = asm_q;
    cnt_next   = cnt;
    word_full  = 1'b0;
    word_part  = 1'b0;
    if (state == LOAD) begin
      if (load_valid) begin
        asm_next[{cnt, 3'b000} +: 8] = load_byte;
        cnt_next  = cnt + 2'd1;
        word_full = (cnt == 2'd3);
      end
      // Same-cycle byte is folded in first; a completed word already covers it.
      if (load_done) begin
        state_next = RUN;
        word_part  = !word_full && (cnt_next != 2'd0);
      end
    end
    word_wr = word_full | word_part;
    wr_en   = word_wr && !wp[ADDR_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      cnt       <= '0;
      asm_q     <= '0;
      wp        <= '0;
      load_ovf  <= 1'b0;
      rd_ok_q   <= 1'b0;
      hit_q     <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == LOAD) begin
        cnt   <= word_wr ? 2'd0 : cnt_next;
        asm_q <= word_wr ? 32'd0 : asm_next;
        if (word_wr) begin
          if (wp[ADDR_W]) load_ovf <= 1'b1;
          else            wp       <= wp + (ADDR_W+1)'(1);
        end
      end
      rd_ok_q   <= (state == RUN) && ce && aligned && in_range;
      fetch_err <= (state == RUN) && ce && !(aligned && in_range);
      // Words at or above the load high-water mark read as zero instead of stale data.
      hit_q     <= ({1'b0, ridx} < wp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wp[ADDR_W-1:0]] <= asm_next;
    if (state == RUN && ce) rd_q <= mem[ridx];
  end

  always_comb begin
    inst_valid = rd_ok_q | fetch_err;
    if (fetch_err)             inst = NOP;
    else if (rd_ok_q && hit_q) inst = rd_q;
    else                       inst = '0;
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: two instances (ADDR_W=10 and ADDR_W=2) share one stimulus
// stream and are checked against a byte-image reference model.
module tb_inst_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_done = 1'b0;

  logic [31:0] inst_a, inst_b;
  logic        inst_valid_a, inst_valid_b, stall_a, stall_b;
  logic        err_a, err_b, ovf_a, ovf_b;

  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned img[$];

  always #5 clk = ~clk;

  inst_mem_resp #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_a), .inst_valid(inst_valid_a),
    .stall_req(stall_a), .load_valid(load_valid), .load_byte(load_byte),
    .load_done(load_done), .fetch_err(err_a), .load_ovf(ovf_a));

  inst_mem_resp #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b), .inst_valid(inst_valid_b),
    .stall_req(stall_b), .load_valid(load_valid), .load_byte(load_byte),
    .load_done(load_done), .fetch_err(err_b), .load_ovf(ovf_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word idx of the loaded image, little-endian, zero past the image end.
  function automatic logic [31:0] model_word(input int unsigned idx);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++)
      if (4 * idx + k < img.size()) w[8*k +: 8] = img[4*idx + k];
    return w;
  endfunction

  function automatic logic [32:0] model_fetch(input int unsigned aw, input logic [31:0] a);
    if (a[1:0] != 2'b00 || (a >> 2) >= (32'd1 << aw)) return {1'b1, 32'h0000_0013};
    return {1'b0, model_word(a >> 2)};
  endfunction

  function automatic logic model_ovf(input int unsigned aw);
    return ((img.size() + 3) / 4) > (1 << aw);
  endfunction

  task automatic check_fetch(input string tag, input logic [31:0] a);
    logic [32:0] ea, eb;
    ea = model_fetch(10, a);
    eb = model_fetch(2, a);
    chk({tag, "_inst_a"}, inst_a, ea[31:0]);
    chk({tag, "_err_a"}, 32'(err_a), 32'(ea[32]));
    chk({tag, "_valid_a"}, 32'(inst_valid_a), 32'd1);
    chk({tag, "_inst_b"}, inst_b, eb[31:0]);
    chk({tag, "_err_b"}, 32'(err_b), 32'(eb[32]));
    chk({tag, "_valid_b"}, 32'(inst_valid_b), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_inst_a"}, inst_a, 32'd0);
    chk({tag, "_valid_a"}, 32'(inst_valid_a), 32'd0);
    chk({tag, "_err_a"}, 32'(err_a), 32'd0);
    chk({tag, "_inst_b"}, inst_b, 32'd0);
    chk({tag, "_valid_b"}, 32'(inst_valid_b), 32'd0);
    chk({tag, "_err_b"}, 32'(err_b), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_idle(tag);
    chk({tag, "_stall_a"}, 32'(stall_a), 32'd1);
    chk({tag, "_stall_b"}, 32'(stall_b), 32'd1);
    chk({tag, "_ovf_a"}, 32'(ovf_a), 32'd0);
    chk({tag, "_ovf_b"}, 32'(ovf_b), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    load_valid = 1'b0;
    load_done  = 1'b0;
    ce         = 1'b0;
    rst        = 1'b0;
    #1;
    check_reset_state(tag);
    img.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a);
    ce   = 1'b1;
    addr = a;
    step();
    ce = 1'b0;
    check_fetch(tag, a);
  endtask

  // Streams img into both DUTs; done either rides on the last byte or follows it.
  task automatic load_img(input string tag, input bit with_last, input bit gaps);
    for (int i = 0; i < img.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        step();
      end
      load_valid = 1'b1;
      load_byte  = img[i];
      load_done  = with_last && (i == img.size() - 1);
      step();
    end
    load_valid = 1'b0;
    chk({tag, "_stall_load_a"}, 32'(stall_a), with_last ? 32'd0 : 32'd1);
    if (!with_last) begin
      load_done = 1'b1;
      step();
    end
    load_done = 1'b0;
    chk({tag, "_stall_run_a"}, 32'(stall_a), 32'd0);
    chk({tag, "_stall_run_b"}, 32'(stall_b), 32'd0);
    chk({tag, "_ovf_a"}, 32'(ovf_a), 32'(model_ovf(10)));
    chk({tag, "_ovf_b"}, 32'(ovf_b), 32'(model_ovf(2)));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return {25'd0, 3'($urandom_range(0, 7)), 2'b00};
      1:       return 32'($urandom_range(0, 40));
      2:       return (32'd1024 + 32'($urandom_range(0, 3))) << 2;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    do_reset("reset0");

    img = {8'h13, 8'h05, 8'h00, 8'h00};
    load_img("ld_nop", 1'b0, 1'b0);
    do_fetch("f_li", 32'h0);
    do_fetch("f_unwritten", 32'h4);

    do_reset("reset1");
    img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    load_img("ld_5b", 1'b1, 1'b0);
    do_fetch("f5_w0", 32'h0);
    do_fetch("f5_w1", 32'h4);
    do_fetch("f5_w2", 32'h8);
    do_fetch("f_misalign", 32'h2);
    do_fetch("f_oor_a", 32'h1000);
    do_fetch("f_oor_b", 32'h10);
    do_fetch("f_top", 32'hFFFF_FFFC);

    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(4 * i);
      step();
      check_fetch("b2b", 32'(4 * i));
    end
    ce = 1'b0;
    step();
    check_idle("ce_off");

    do_reset("reset2");
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
    load_img("ld_ovf", 1'($urandom_range(0, 1)), 1'b1);
    chk("ovf_b_set", 32'(ovf_b), 32'd1);
    for (int i = 0; i < 5; i++) do_fetch("f_ovf", 32'(4 * i));
    load_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      load_byte = 8'hAA;
      load_done = (i == 8);
      step();
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
    chk("run_ld_stall", 32'(stall_a), 32'd0);
    for (int i = 0; i < 5; i++) do_fetch("f_runld", 32'(4 * i));

    ce   = 1'b1;
    addr = 32'h0;
    step();
    chk("inflight_valid", 32'(inst_valid_a), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("rst_inflight");
    img.delete();
    ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_byte = 8'hEE;
      step();
    end
    load_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("rst_midload");
    @(negedge clk);
    rst = 1'b1;
    img = {8'h93, 8'h00, 8'h10, 8'h00, 8'h37};
    load_img("reload", 1'b0, 1'b0);
    do_fetch("rl_w0", 32'h0);
    do_fetch("rl_w1", 32'h4);

    for (int r = 0; r < 6; r++) begin
      do_reset("reset_r");
      for (int i = 0, n = $urandom_range(1, 24); i < n; i++) img.push_back(8'($urandom));
      load_img("ld_r", 1'($urandom_range(0, 1)), 1'b1);
      for (int j = 0; j < 12; j++) begin
        if ($urandom_range(0, 5) == 0) begin
          ce   = 1'b0;
          addr = $urandom;
          step();
          check_idle("r_idle");
        end else begin
          do_fetch("r_fetch", rand_addr());
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of instruction-memory depth in 32-bit words (1024 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ce, input, 1, fetch enable from the core.
REQ-005 SHALL have port addr, input, 32, byte address of the fetch.
REQ-006 SHALL have port inst, output, 32, fetched instruction word.
REQ-007 SHALL have port inst_valid, output, 1, inst holds the result of the previous cycle's fetch.
REQ-008 SHALL have port stall_req, output, 1, core must hold its PC.
REQ-009 SHALL have port load_valid, input, 1, load_byte is valid this cycle.
REQ-010 SHALL have port load_byte, input, 8, program-image byte.
REQ-011 SHALL have port load_done, input, 1, single-cycle end-of-image pulse.
REQ-012 SHALL have port fetch_err, output, 1, previous fetch was misaligned or out of range.
REQ-013 SHALL have port load_ovf, output, 1, sticky flag: image exceeded memory depth.

Function
REQ-014 SHALL implement two states, LOAD and RUN; reset enters LOAD.
REQ-015 SHALL drive stall_req=1 in LOAD and stall_req=0 in RUN.
REQ-016 In LOAD, each load_valid byte SHALL go into byte lane cnt of an assembly register, little-endian: lane 0 = bits 7:0; cnt is a 2-bit counter.
REQ-017 On the 4th byte (cnt=3 with load_valid), SHALL write the assembled word at word pointer wp in that cycle, increment wp, and clear cnt.
REQ-018 wp SHALL be ADDR_W+1 bits wide; once wp reaches 2^ADDR_W, further word writes SHALL be dropped and load_ovf SHALL be set. wp SHALL not wrap.
REQ-019 On load_done in LOAD with cnt!=0, SHALL write the partial word with unfilled upper lanes zero, subject to the REQ-018 limit.
REQ-020 load_done SHALL move the FSM to RUN on the next edge.
REQ-021 If load_valid and load_done occur in the same cycle, the byte SHALL be accepted first, then completion handled per REQ-019/REQ-020 including that byte.
REQ-022 In RUN, load_valid and load_done SHALL be ignored; re-loading requires reset.
REQ-023 In RUN, a fetch is accepted when ce=1 at a rising edge; its results appear one cycle later (latency 1).
REQ-024 For an accepted fetch with addr[1:0]=00 and addr[31:2] < 2^ADDR_W: next cycle inst = mem[addr[ADDR_W+1:2]], inst_valid=1, fetch_err=0.
REQ-025 For an accepted fetch with addr[1:0]!=00 or addr[31:2] >= 2^ADDR_W: next cycle inst=32'h00000013 (NOP), inst_valid=1, fetch_err=1.
REQ-026 When ce=0 at a RUN edge, or at any LOAD edge: next cycle inst=0, inst_valid=0, fetch_err=0.
REQ-027 Words never written SHALL read as 0; memory SHALL be cleared by the load sequence through a zero-fill of unloaded words, or by initialisation. Contents are not required to survive reset.
REQ-028 Memory SHALL be synchronous: one write port used in LOAD, one read port used in RUN.

Reset
REQ-029 Asserting rst=0 SHALL immediately force: state=LOAD, stall_req=1, inst=0, inst_valid=0, fetch_err=0, load_ovf=0, cnt=0, wp=0.
REQ-030 Reset asserted mid-load or mid-fetch SHALL discard the partial word and any fetch in flight; nothing is written on the reset edge.
REQ-031 After rst deasserts, the first edge SHALL operate in LOAD.

Verification
REQ-032 Load bytes 13,05,00,00 then pulse load_done; fetch addr 0 with ce=1 -> next cycle inst=32'h00000513, inst_valid=1, stall_req=0.
REQ-033 Load 5 bytes 01..05 with load_done on the 5th byte -> mem[0]=32'h04030201, mem[1]=32'h00000005, RUN entered.
REQ-034 In RUN, fetch addr 32'h2 -> inst=32'h00000013, fetch_err=1; fetch addr 32'h1000 with ADDR_W=10 -> same response.
REQ-035 Back-to-back fetches of addr 0,4,8 with ce=1 -> inst sequence mem[0],mem[1],mem[2] on consecutive cycles; ce=0 -> inst_valid=0 the next cycle.
REQ-036 With ADDR_W=2, load 20 bytes -> load_ovf=1, mem[0..3] hold the first 16 bytes; load_valid bytes in RUN leave memory unchanged.
REQ-037 Assert rst=0 after 2 bytes of a word -> stall_req=1 and inst_valid=0 immediately; reload from wp=0 succeeds.
